// File: rtl/axi_rd_arbiter_if.sv
// Bundles the per-requester AXI read slave ports and the shared read master port of the arbiter.
// Requester-side buses are flat vectors with requester i in slice [i*W +: W].
interface axi_rd_arbiter_if #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int S_ID_WIDTH = 8,
    parameter int M_ID_WIDTH = S_ID_WIDTH + $clog2(S_COUNT)
);
    logic [S_COUNT*S_ID_WIDTH-1:0] s_axi_arid;
    logic [S_COUNT*ADDR_WIDTH-1:0] s_axi_araddr;
    logic [S_COUNT*8-1:0]          s_axi_arlen;
    logic [S_COUNT*3-1:0]          s_axi_arsize;
    logic [S_COUNT*2-1:0]          s_axi_arburst;
    logic [S_COUNT-1:0]            s_axi_arvalid;
    logic [S_COUNT-1:0]            s_axi_arready;
    logic [S_COUNT*S_ID_WIDTH-1:0] s_axi_rid;
    logic [S_COUNT*DATA_WIDTH-1:0] s_axi_rdata;
    logic [S_COUNT*2-1:0]          s_axi_rresp;
    logic [S_COUNT-1:0]            s_axi_rlast;
    logic [S_COUNT-1:0]            s_axi_rvalid;
    logic [S_COUNT-1:0]            s_axi_rready;

    logic [M_ID_WIDTH-1:0]         m_axi_arid;
    logic [ADDR_WIDTH-1:0]         m_axi_araddr;
    logic [7:0]                    m_axi_arlen;
    logic [2:0]                    m_axi_arsize;
    logic [1:0]                    m_axi_arburst;
    logic                          m_axi_arvalid;
    logic                          m_axi_arready;
    logic [M_ID_WIDTH-1:0]         m_axi_rid;
    logic [DATA_WIDTH-1:0]         m_axi_rdata;
    logic [1:0]                    m_axi_rresp;
    logic                          m_axi_rlast;
    logic                          m_axi_rvalid;
    logic                          m_axi_rready;

    // Arbiter view
    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    // Environment view: requesters plus downstream memory
    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI read arbiter: one AR per two cycles, AR registered (1 cycle), R routed combinationally by ID prefix.
// AR grants stall while M_ISSUE bursts are outstanding; R backpressure follows the selected requester's rready.
module axi_rd_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int S_ID_WIDTH = 8,
    parameter int M_ID_WIDTH = S_ID_WIDTH + $clog2(S_COUNT),
    parameter int M_ISSUE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    axi_rd_arbiter_if.slave  bus
);
    localparam int IDX_W = M_ID_WIDTH - S_ID_WIDTH;
    localparam int CNT_W = $clog2(M_ISSUE + 1);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  arvalid_q, arvalid_d;
    logic [M_ID_WIDTH-1:0] arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;

    logic                  req_found;
    logic [IDX_W-1:0]      req_idx;
    logic                  grant_en;
    logic [IDX_W-1:0]      r_sel;
    logic                  r_sel_ok;
    logic                  m_rready;
    logic                  inc;
    logic                  dec;
    int                    idx;

    // First requester at or after rr_ptr, wrapping
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        idx       = 0;
        for (int i = 0; i < S_COUNT; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= S_COUNT) idx = idx - S_COUNT;
            if (!req_found && bus.s_axi_arvalid[idx]) begin
                req_found = 1'b1;
                req_idx   = IDX_W'(idx);
            end
        end
    end

    // Reset gating keeps arready low while rst is asserted even though the FSM sits in IDLE
    assign grant_en = (state_q == IDLE) && req_found && (cnt_q < CNT_W'(M_ISSUE)) && !rst;

    always_comb begin
        for (int i = 0; i < S_COUNT; i++) begin
            bus.s_axi_arready[i] = grant_en && (req_idx == IDX_W'(i));
        end
    end

    assign r_sel    = bus.m_axi_rid[M_ID_WIDTH-1:S_ID_WIDTH];
    assign r_sel_ok = {1'b0, r_sel} < (IDX_W+1)'(S_COUNT);

    // Beats tagged for a nonexistent requester are accepted and dropped
    always_comb begin
        m_rready = r_sel_ok ? bus.s_axi_rready[r_sel] : 1'b1;
        for (int i = 0; i < S_COUNT; i++) begin
            bus.s_axi_rvalid[i] = r_sel_ok && bus.m_axi_rvalid && (r_sel == IDX_W'(i));
        end
    end

    assign bus.m_axi_rready = m_rready;
    assign bus.s_axi_rid    = {S_COUNT{bus.m_axi_rid[S_ID_WIDTH-1:0]}};
    assign bus.s_axi_rdata  = {S_COUNT{bus.m_axi_rdata}};
    assign bus.s_axi_rresp  = {S_COUNT{bus.m_axi_rresp}};
    assign bus.s_axi_rlast  = {S_COUNT{bus.m_axi_rlast}};

    assign inc = (state_q == ISSUE) && bus.m_axi_arready;
    assign dec = bus.m_axi_rvalid && m_rready && bus.m_axi_rlast && (cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    state_d   = ISSUE;
                    arvalid_d = 1'b1;
                    grant_d   = req_idx;
                    arid_d    = {req_idx, bus.s_axi_arid[req_idx*S_ID_WIDTH +: S_ID_WIDTH]};
                    araddr_d  = bus.s_axi_araddr[req_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    arlen_d   = bus.s_axi_arlen[req_idx*8 +: 8];
                    arsize_d  = bus.s_axi_arsize[req_idx*3 +: 3];
                    arburst_d = bus.s_axi_arburst[req_idx*2 +: 2];
                end
            end
            ISSUE: begin
                if (bus.m_axi_arready) begin
                    state_d   = IDLE;
                    arvalid_d = 1'b0;
                    rr_ptr_d  = (grant_q == IDX_W'(S_COUNT - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (inc && !dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
        end
    end

    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_arid    = arid_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = arsize_q;
    assign bus.m_axi_arburst = arburst_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: round-robin order, issue limit, R routing, reset abandonment.
module tb_axi_rd_arbiter;
    localparam int S_COUNT    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int S_ID_WIDTH = 8;
    localparam int M_ID_WIDTH = 10;
    localparam int M_ISSUE    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(
        .S_COUNT(S_COUNT), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .S_ID_WIDTH(S_ID_WIDTH), .M_ID_WIDTH(M_ID_WIDTH)
    ) bus ();

    axi_rd_arbiter #(
        .S_COUNT(S_COUNT), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .S_ID_WIDTH(S_ID_WIDTH), .M_ID_WIDTH(M_ID_WIDTH), .M_ISSUE(M_ISSUE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  ids   [S_COUNT];
    logic [31:0] addrs [S_COUNT];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [7:0] id);
        ids[p]   = id;
        addrs[p] = 32'h1000_0000 + 32'(p * 32'h100);
        bus.s_axi_arid[p*8 +: 8]     = id;
        bus.s_axi_araddr[p*32 +: 32] = addrs[p];
        bus.s_axi_arlen[p*8 +: 8]    = 8'(p + 1);
        bus.s_axi_arsize[p*3 +: 3]   = 3'd2;
        bus.s_axi_arburst[p*2 +: 2]  = 2'b01;
    endtask

    // Full grant/issue of one AR with m_axi_arready already high
    task automatic issue(input int p, input string tag);
        logic [3:0] e_rdy;
        logic [9:0] e_id;
        e_rdy = 4'b0001 << p;
        e_id  = 10'((p << 8) | int'(ids[p]));
        chk({tag, "_ardy"}, 64'(bus.s_axi_arready), 64'(e_rdy));
        tick();
        chk({tag, "_mvld"}, 64'(bus.m_axi_arvalid), 64'(1));
        chk({tag, "_mid"}, 64'(bus.m_axi_arid), 64'(e_id));
        chk({tag, "_maddr"}, 64'(bus.m_axi_araddr), 64'(addrs[p]));
        chk({tag, "_mlen"}, 64'(bus.m_axi_arlen), 64'(p + 1));
        chk({tag, "_ardy_off"}, 64'(bus.s_axi_arready), 64'(0));
        tick();
        chk({tag, "_mvld_off"}, 64'(bus.m_axi_arvalid), 64'(0));
    endtask

    task automatic rbeat(input logic [9:0] rid);
        bus.m_axi_rid    = rid;
        bus.m_axi_rlast  = 1'b1;
        bus.m_axi_rvalid = 1'b1;
        bus.s_axi_rready = 4'hF;
        #1;
        tick();
        bus.m_axi_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
        bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
        bus.s_axi_arvalid = 4'hF;
        bus.s_axi_rready = 4'h0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = '0;
        bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
        for (int p = 0; p < S_COUNT; p++) set_port(p, 8'(8'h10 + p));

        repeat (2) tick();
        chk("rst_mvld", 64'(bus.m_axi_arvalid), 64'(0));
        chk("rst_ardy", 64'(bus.s_axi_arready), 64'(0));
        chk("rst_mid", 64'(bus.m_axi_arid), 64'(0));
        chk("rst_maddr", 64'(bus.m_axi_araddr), 64'(0));

        // All four request together: grants 0,1,2,3 until the issue limit
        rst = 1'b0;
        bus.m_axi_arready = 1'b1;
        #1;
        for (int p = 0; p < S_COUNT; p++) issue(p, "rr");
        chk("limit_ardy0", 64'(bus.s_axi_arready), 64'(0));
        tick();
        chk("limit_ardy1", 64'(bus.s_axi_arready), 64'(0));

        // One rlast beat for requester 1 frees a slot
        bus.m_axi_rid    = 10'h110;
        bus.m_axi_rdata  = 32'hDEAD_BEEF;
        bus.m_axi_rresp  = 2'b01;
        bus.m_axi_rlast  = 1'b1;
        bus.m_axi_rvalid = 1'b1;
        bus.s_axi_rready = 4'hF;
        #1;
        chk("r1_svld", 64'(bus.s_axi_rvalid), 64'(4'b0010));
        chk("r1_rid2", 64'(bus.s_axi_rid[23:16]), 64'(8'h10));
        chk("r1_data3", 64'(bus.s_axi_rdata[127:96]), 64'(32'hDEAD_BEEF));
        chk("r1_resp3", 64'(bus.s_axi_rresp[7:6]), 64'(2'b01));
        chk("r1_mrdy", 64'(bus.m_axi_rready), 64'(1));
        chk("r1_ardy_still", 64'(bus.s_axi_arready), 64'(0));
        tick();
        bus.m_axi_rvalid = 1'b0;
        #1;
        issue(0, "resume");

        // Routing to requester 3 with backpressure
        bus.s_axi_arvalid = 4'h0;
        bus.m_axi_rid     = 10'h3C7;
        bus.m_axi_rlast   = 1'b1;
        bus.m_axi_rvalid  = 1'b1;
        bus.s_axi_rready  = 4'b0111;
        #1;
        chk("r3_svld", 64'(bus.s_axi_rvalid), 64'(4'b1000));
        chk("r3_rid0", 64'(bus.s_axi_rid[7:0]), 64'(8'hC7));
        chk("r3_rid3", 64'(bus.s_axi_rid[31:24]), 64'(8'hC7));
        chk("r3_mrdy_low", 64'(bus.m_axi_rready), 64'(0));
        tick();
        chk("r3_svld_hold", 64'(bus.s_axi_rvalid), 64'(4'b1000));
        bus.s_axi_rready = 4'hF;
        #1;
        chk("r3_mrdy_high", 64'(bus.m_axi_rready), 64'(1));
        tick();
        bus.m_axi_rid = 10'h000;
        tick();
        bus.m_axi_rvalid = 1'b0;
        #1;

        // Outstanding is 2: AR handshake and rlast in the same cycle leave it at 2
        bus.s_axi_arvalid = 4'b0100;
        #1;
        chk("same_ardy", 64'(bus.s_axi_arready), 64'(4'b0100));
        tick();
        chk("same_mid", 64'(bus.m_axi_arid), 64'(10'h212));
        bus.m_axi_rid    = 10'h000;
        bus.m_axi_rvalid = 1'b1;
        #1;
        tick();
        bus.m_axi_rvalid  = 1'b0;
        bus.s_axi_arvalid = 4'b0001;
        #1;
        issue(0, "same_a");
        bus.s_axi_arvalid = 4'b0010;
        #1;
        issue(1, "same_b");
        bus.s_axi_arvalid = 4'hF;
        #1;
        chk("same_stall", 64'(bus.s_axi_arready), 64'(0));

        // Hold master arready low: AR stays presented and stable
        bus.s_axi_arvalid = 4'h0;
        rbeat(10'h000);
        rbeat(10'h000);
        set_port(2, 8'h5A);
        bus.s_axi_arvalid = 4'b0100;
        bus.m_axi_arready = 1'b0;
        #1;
        chk("hold_ardy", 64'(bus.s_axi_arready), 64'(4'b0100));
        tick();
        bus.s_axi_arvalid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_mvld", 64'(bus.m_axi_arvalid), 64'(1));
            chk("hold_mid", 64'(bus.m_axi_arid), 64'(10'h25A));
            chk("hold_ardy_off", 64'(bus.s_axi_arready), 64'(0));
            tick();
        end

        // Reset while issuing: AR dropped at once, next grant goes to port 0
        rst = 1'b1;
        #1;
        chk("rsti_mvld", 64'(bus.m_axi_arvalid), 64'(0));
        chk("rsti_ardy", 64'(bus.s_axi_arready), 64'(0));
        chk("rsti_mid", 64'(bus.m_axi_arid), 64'(0));
        tick();
        rst = 1'b0;
        bus.m_axi_arready = 1'b1;
        #1;
        for (int p = 0; p < S_COUNT; p++) issue(p, "post_rst");
        chk("post_rst_stall", 64'(bus.s_axi_arready), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
